ram_bus_ctrl: RTL and testbench
===============================

RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning SRAM word-address width (depth 2^AW words of 32 bits).
REQ-002 The block SHALL have parameter CLR_EN, default 1, meaning zero-fill of the whole SRAM after reset when 1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i in 1, system clock (all logic on rising edge); rst_n_i in 1, asynchronous active-low reset.
REQ-004 The block SHALL have port mem_valid_i in 1: request valid, held high until mem_ready_o pulses.
REQ-005 The block SHALL have port mem_addr_i in 32: byte address; bits [AW+1:2] select the word, and all other bits are ignored.
REQ-006 The block SHALL have port mem_wdata_i in 32: write data.
REQ-007 The block SHALL have port mem_wstrb_i in 4: byte write strobes; 0 means read.
REQ-008 The block SHALL have port mem_ready_o out 1: one-cycle completion pulse.
REQ-009 The block SHALL have port mem_rdata_o out 32: read data, valid while mem_ready_o is high for a read.
REQ-010 The block SHALL have SRAM-side ports: ram_cs_o out 1; ram_addr_o out AW; ram_data_o out 32; ram_mask_o out 4; ram_wren_o out 1; ram_data_i in 32 (read data, one cycle after a cs read).
REQ-011 The block SHALL have port init_done_o out 1: high once the zero-fill has finished, or immediately after reset when CLR_EN=0.

Function
REQ-012 The FSM SHALL have states INIT, IDLE, RD_WAIT and RESP.
REQ-013 Leaving reset, the FSM SHALL enter INIT when CLR_EN=1 and IDLE otherwise.
REQ-014 In INIT, each cycle SHALL drive ram_cs_o=1, ram_wren_o=1, ram_mask_o=4'hF, ram_data_o=0 and ram_addr_o=clear counter.
REQ-015 In INIT, the clear counter SHALL increment from 0 to 2^AW-1, then the FSM SHALL go to IDLE and set init_done_o, taking exactly 2^AW INIT cycles.
REQ-016 While in INIT, mem_ready_o SHALL stay 0, and a pending mem_valid_i SHALL be held off and not lost.
REQ-017 In IDLE with mem_valid_i=1 and wstrb≠0, the block SHALL, in the same cycle, drive ram_cs_o=1, ram_wren_o=1, ram_mask_o=wstrb, ram_data_o=wdata, ram_addr_o=word address, then go to RESP.
REQ-018 In IDLE with mem_valid_i=1 and wstrb=0, the block SHALL, in the same cycle, drive ram_cs_o=1, ram_wren_o=0, ram_mask_o=0 and ram_addr_o=word address, then go to RD_WAIT.
REQ-019 In RD_WAIT, the block SHALL register ram_data_i into the mem_rdata_o register and go to RESP.
REQ-020 In RESP, mem_ready_o SHALL be 1 for exactly one cycle, then the FSM SHALL go unconditionally to IDLE.
REQ-021 Latency from mem_valid_i sampled in IDLE to mem_ready_o SHALL be: write 1 cycle (ready on cycle 2); read 2 cycles (ready on cycle 3).
REQ-022 Throughput SHALL be at most one request per 2 cycles (write) or 3 cycles (read), because RESP always returns to IDLE, so a requester dropping valid after ready never re-issues.
REQ-023 ram_cs_o SHALL be 0 in RD_WAIT, RESP and idle IDLE cycles.
REQ-024 ram_wren_o, ram_mask_o and ram_data_o SHALL be 0 whenever ram_cs_o=0.
REQ-025 mem_rdata_o SHALL hold its last read value until the next read completes, and SHALL NOT be changed by writes.
REQ-026 Address wrap: bits of mem_addr_i above AW+1 SHALL be discarded, so address 4·2^AW aliases word 0.
REQ-027 Request fields SHALL be sampled only in IDLE; changes to them in RD_WAIT or RESP SHALL be ignored.

Reset
REQ-028 On rst_n_i low, asynchronously: state=INIT (CLR_EN=1) or IDLE (CLR_EN=0), clear counter=0, init_done_o=0 (CLR_EN=1) or 1 (CLR_EN=0), mem_ready_o=0, mem_rdata_o=0, all ram_* outputs 0.
REQ-029 Reset asserted mid-access or mid-INIT SHALL abort the operation with no ready pulse, and the zero-fill SHALL restart from address 0.
REQ-030 Reset deassertion SHALL be used as supplied; the block SHALL contain no internal synchronizer.

Structure
REQ-031 The state encoding (2-bit enum) and the default AW SHALL live in the shared SoC package.
REQ-032 The block SHALL be a single module with no sub-modules; it connects directly to tc_sram_1024x32 with AW=10.

Verification
REQ-033 Bench SHALL cover reset with CLR_EN=1, AW=10: init_done_o rises after exactly 1024 cycles, and a read of any address returns 32'h0.
REQ-034 Bench SHALL cover write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF: ram_cs_o=1, ram_wren_o=1, ram_addr_o=4 in cycle 1, and mem_ready_o in cycle 2.
REQ-035 Bench SHALL cover write 0x11223344 to addr 0x10 with wstrb 4'b0101, then read addr 0x10: result 0xDE22BE44, with mem_ready_o 2 cycles after the read is sampled.
REQ-036 Bench SHALL cover mem_valid_i held high during INIT: no ram access from the request and no ready before init_done_o; the request completes after init.
REQ-037 Bench SHALL cover rst_n_i pulsed low in RD_WAIT: no mem_ready_o pulse, all outputs 0 immediately, and INIT restarting at address 0.
REQ-038 Bench SHALL cover a read at addr 0x1000 (AW=10): ram_addr_o=0, and the returned data equals word 0.

Source files
------------

// File: rtl/ram_bus_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_bus_ctrl_pkg                                                      |
// | Shared SoC types for the SRAM bus controller.                         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ram_bus_ctrl_pkg;

  localparam int RBC_AW_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } rbc_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_bus_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_bus_ctrl                                                          |
// | Valid/ready bus to single-port 32-bit SRAM, with optional zero-fill.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ram_bus_ctrl
  import ram_bus_ctrl_pkg::*;
#(
  parameter int AW     = RBC_AW_DEFAULT,
  parameter bit CLR_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          mem_valid_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_wdata_i,
  input  logic [3:0]    mem_wstrb_i,
  output logic          mem_ready_o,
  output logic [31:0]   mem_rdata_o,
  output logic          ram_cs_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_data_o,
  output logic [3:0]    ram_mask_o,
  output logic          ram_wren_o,
  input  logic [31:0]   ram_data_i,
  output logic          init_done_o
);

  localparam logic [AW-1:0] C_CLR_LAST = '1;

  rbc_state_t    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_init_done;
  logic          r_ready;
  logic [31:0]   r_rdata;

  logic [AW-1:0] w_word;
  logic          w_unused_addr;

  assign w_word        = mem_addr_i[AW+1:2];
  assign w_unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if (CLR_EN) r_state <= ST_INIT;
      else        r_state <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_init_done <= !CLR_EN;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == C_CLR_LAST) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (mem_valid_i) begin
            if (|mem_wstrb_i) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          r_rdata <= ram_data_i;
          r_state <= ST_RESP;
          r_ready <= 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobes are issued in the same cycle as the request, so they are
  // decoded from state; reset forces them low without waiting for a clock.
  always_comb begin
    ram_cs_o   = 1'b0;
    ram_wren_o = 1'b0;
    ram_mask_o = '0;
    ram_data_o = '0;
    ram_addr_o = '0;
    if (rst_n_i) begin
      case (r_state)
        ST_INIT: begin
          ram_cs_o   = 1'b1;
          ram_wren_o = 1'b1;
          ram_mask_o = 4'hF;
          ram_addr_o = r_clr_cnt;
        end
        ST_IDLE: begin
          if (mem_valid_i) begin
            ram_cs_o   = 1'b1;
            ram_addr_o = w_word;
            if (|mem_wstrb_i) begin
              ram_wren_o = 1'b1;
              ram_mask_o = mem_wstrb_i;
              ram_data_o = mem_wdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_ready_o = r_ready;
  assign mem_rdata_o = r_rdata;
  assign init_done_o = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ram_bus_ctrl                                                       |
// | Self-checking bench: transaction-level reference model plus SRAM.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ram_bus_ctrl;

  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic [3:0]    ram_mask;
  logic          ram_wren;
  logic [31:0]   ram_q = '0;
  logic          init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_bus_ctrl #(.AW(AW), .CLR_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_ready_o (mem_ready),
    .mem_rdata_o (mem_rdata),
    .ram_cs_o    (ram_cs),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_data),
    .ram_mask_o  (ram_mask),
    .ram_wren_o  (ram_wren),
    .ram_data_i  (ram_q),
    .init_done_o (init_done)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Simple synchronous SRAM, seeded with garbage so the zero-fill is visible.
  logic [31:0] sram [0:N-1];
  bit          sram_seeded = 1'b0;
  always @(posedge clk) begin
    if (!sram_seeded) begin
      for (int i = 0; i < N; i++) sram[i] <= $urandom();
      sram_seeded <= 1'b1;
    end else if (ram_cs) begin
      if (ram_wren) begin
        for (int b = 0; b < 4; b++)
          if (ram_mask[b]) sram[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
      end else begin
        ram_q <= sram[ram_addr];
      end
    end
  end

  // Reference model: cycle k counts clocks since reset release. The first N
  // cycles are the clear sweep; afterwards a request seen when the block is
  // free is served with ready one (write) or two (read) cycles later.
  int          k = 0;
  int          free_at = N;
  int          ready_at = -1;
  bit          rd_pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] mdl [0:N-1];

  always @(negedge clk) begin
    logic          e_cs, e_wren, e_rdy, e_done;
    logic [3:0]    e_mask;
    logic [31:0]   e_data;
    logic [AW-1:0] e_addr;
    logic [AW-1:0] word;
    e_cs = 1'b0; e_wren = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
    e_mask = '0; e_data = '0; e_addr = '0; word = '0;
    if (!rst_n) begin
      k = 0; free_at = N; ready_at = -1; rd_pend = 1'b0; exp_rdata = '0;
      for (int i = 0; i < N; i++) mdl[i] = '0;
    end else begin
      e_done = (k >= N);
      if (k < N) begin
        e_cs = 1'b1; e_wren = 1'b1; e_mask = 4'hF; e_addr = k[AW-1:0];
      end else begin
        e_rdy = (k == ready_at);
        if (e_rdy && rd_pend) exp_rdata = pend_data;
        if (mem_valid && k >= free_at) begin
          word   = mem_addr[AW+1:2];
          e_cs   = 1'b1;
          e_addr = word;
          if (mem_wstrb != 4'h0) begin
            e_wren = 1'b1; e_mask = mem_wstrb; e_data = mem_wdata;
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mdl[word][8*b +: 8] = mem_wdata[8*b +: 8];
            ready_at = k + 1;
            rd_pend  = 1'b0;
          end else begin
            pend_data = mdl[word];
            ready_at  = k + 2;
            rd_pend   = 1'b1;
          end
          free_at = ready_at + 1;
        end
      end
      k++;
    end
    chk("ready",     {31'b0, mem_ready}, {31'b0, e_rdy});
    chk("rdata",     mem_rdata, exp_rdata);
    chk("init_done", {31'b0, init_done}, {31'b0, e_done});
    chk("ram_cs",    {31'b0, ram_cs}, {31'b0, e_cs});
    chk("ram_wren",  {31'b0, ram_wren}, {31'b0, e_wren});
    chk("ram_mask",  {28'b0, ram_mask}, {28'b0, e_mask});
    chk("ram_data",  ram_data, e_data);
    chk("ram_addr",  {{(32-AW){1'b0}}, ram_addr}, {{(32-AW){1'b0}}, e_addr});
  end

  // Issues one request (called at #1 after a rising edge) and holds it until
  // ready; returns the cycle index of ready counted from the issue cycle = 1.
  task automatic req(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit scramble,
                     output logic [31:0] rd, output int cyc,
                     output logic cs1, output logic [AW-1:0] addr1,
                     output logic wren1, output logic done_rdy);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    cyc = 0; rd = '0; cs1 = 1'b0; addr1 = '0; wren1 = 1'b0; done_rdy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin cs1 = ram_cs; addr1 = ram_addr; wren1 = ram_wren; end
      if (mem_ready) begin rd = mem_rdata; done_rdy = init_done; break; end
      if (cyc > 3000) begin chk("req_timeout", 32'd0, 32'd1); break; end
      @(posedge clk); #1;
      if (scramble) begin
        mem_addr = $urandom(); mem_wdata = $urandom(); mem_wstrb = 4'($urandom());
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0]   rd, a, wd;
    logic [3:0]    ws;
    logic          cs1, wren1, done_rdy;
    logic [AW-1:0] addr1;
    int            cyc, cnt, gap;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs",    {31'b0, ram_cs}, 32'd0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_done",  {31'b0, init_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    cnt = 0;
    while (cnt < 2000) begin
      @(negedge clk);
      if (init_done) break;
      cnt++;
    end
    chk("init_cycles", cnt, 32'd1024);
    @(posedge clk); #1;

    req(32'h20, 32'h0, 4'h0, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("read_after_clear", rd, 32'h0);
    chk("read_latency", cyc, 32'd3);

    req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("wr_cs",      {31'b0, cs1}, 32'd1);
    chk("wr_wren",    {31'b0, wren1}, 32'd1);
    chk("wr_addr",    {22'b0, addr1}, 32'd4);
    chk("wr_latency", cyc, 32'd2);

    req(32'h10, 32'h11223344, 4'b0101, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    req(32'h10, 32'h0, 4'h0, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("partial_wr", rd, 32'hDE22BE44);
    chk("rd_latency", cyc, 32'd3);

    req(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    req(32'h1000, 32'h0, 4'h0, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("wrap_addr", {22'b0, addr1}, 32'd0);
    chk("wrap_data", rd, 32'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      a = $urandom();
      a[AW+1:2] = AW'($urandom_range(0, 15));
      wd = $urandom();
      ws = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      req(a, wd, ws, 1'b1, rd, cyc, cs1, addr1, wren1, done_rdy);
    end

    // Reset landing in the read-wait cycle.
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_valid = 1'b0;
    #1;
    chk("abort_cs",    {31'b0, ram_cs}, 32'd0);
    chk("abort_ready", {31'b0, mem_ready}, 32'd0);
    chk("abort_rdata", mem_rdata, 32'd0);
    chk("abort_done",  {31'b0, init_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during the clear sweep, then a request held through a full sweep.
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req(32'h40, 32'h12345678, 4'hF, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("held_latency", cyc, 32'd1021);
    chk("held_done",    {31'b0, done_rdy}, 32'd1);
    req(32'h40, 32'h0, 4'h0, 1'b0, rd, cyc, cs1, addr1, wren1, done_rdy);
    chk("held_data", rd, 32'h12345678);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
